// File: rtl/serial_feeder.sv
// Parallel-to-serial front end for the 1011 detector: takes words over valid/ready
// and streams them LSB-first with no gap between back-to-back words.
module serial_feeder #(
  parameter int WIDTH  = 23,
  parameter int LEN_W  = 5,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  LOAD_DATA,
  input  logic [LEN_W-1:0]  LOAD_LEN,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  output logic              DOUT,
  output logic              DOUT_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic [WCNT_W-1:0] WORDS_SENT
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] remaining;
  logic             pend_empty;
  logic             last_bit;
  logic             accept;
  logic [LEN_W-1:0] eff_len;
  logic             len_zero;
  logic             next_done;

  // pend_empty holds the completion of a zero-length word that arrived while a
  // previous word's DONE was already claiming the next cycle.
  always_comb begin
    last_bit   = (state == SHIFT) && (remaining == LEN_W'(1));
    LOAD_READY = (state == IDLE) || last_bit;
    accept     = LOAD_VALID && LOAD_READY;
    eff_len    = (LOAD_LEN > MAX_LEN) ? MAX_LEN : LOAD_LEN;
    len_zero   = (eff_len == '0);
    next_done  = last_bit || ((state == IDLE) && (pend_empty || (accept && len_zero)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      remaining  <= '0;
      pend_empty <= 1'b0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      WORDS_SENT <= '0;
    end else begin
      DONE       <= next_done;
      if (next_done)
        WORDS_SENT <= WORDS_SENT + 1'b1;
      pend_empty <= accept && len_zero && (last_bit || pend_empty);

      if (accept && !len_zero) begin
        state      <= SHIFT;
        shreg      <= LOAD_DATA >> 1;
        remaining  <= eff_len;
        DOUT       <= LOAD_DATA[0];
        DOUT_VALID <= 1'b1;
        BUSY       <= 1'b1;
      end else if (last_bit) begin
        state      <= IDLE;
        shreg      <= '0;
        remaining  <= '0;
        DOUT       <= 1'b0;
        DOUT_VALID <= 1'b0;
        BUSY       <= 1'b0;
      end else if (state == SHIFT) begin
        shreg      <= shreg >> 1;
        remaining  <= remaining - 1'b1;
        DOUT       <= shreg[0];
      end
    end
  end

endmodule
